// File: rtl/bus_arbiter_rr_if.sv
// Request/grant bundle shared by the bus arbiter and the masters it serves.
// Latency: none, wiring only.
// Backpressure: none; masters hold DMA high until granted, and BUS_req/BUS_ready stretch a grant.
//
// Ports carried:
//   DMA       per-channel bus request (masters -> arbiter)
//   BUS_req   slave request driven by the owning master
//   BUS_ready slave completion strobe for the current transfer
//   grant     one-hot bus grant, zero when nobody owns the bus
//   owner     index of the current or last owner
//   bus_busy  high while a grant is active
//   preempt   one-cycle pulse when a grant is withdrawn by timeout
interface bus_arbiter_rr_if #(
    parameter int N_CH = 8
);
    localparam int IDX_W = $clog2(N_CH);

    logic [N_CH-1:0]  DMA;
    logic             BUS_req;
    logic             BUS_ready;
    logic [N_CH-1:0]  grant;
    logic [IDX_W-1:0] owner;
    logic             bus_busy;
    logic             preempt;

    // Arbiter side.
    modport master (
        input  DMA, BUS_req, BUS_ready,
        output grant, owner, bus_busy, preempt
    );

    // Requesting masters / bus side.
    modport slave (
        output DMA, BUS_req, BUS_ready,
        input  grant, owner, bus_busy, preempt
    );
endinterface

// File: rtl/bus_arbiter_rr.sv
// Shared-bus arbiter: round-robin or fixed priority, bounded hold with preemption, one dead cycle between owners.
// Latency: grant one cycle after a request is sampled in IDLE; one HANDOVER cycle between successive owners.
// Backpressure: an in-flight transfer (BUS_req & ~BUS_ready) holds the current grant until BUS_ready.
//
// Ports:
//   clk  system clock, rising edge
//   clr  asynchronous active-high reset; clears grant immediately
//   bus  bus_arbiter_rr_if.master (DMA, BUS_req, BUS_ready in; grant, owner, bus_busy, preempt out)
module bus_arbiter_rr #(
    parameter int N_CH     = 8,
    parameter int RR_MODE  = 1,
    parameter int MAX_HOLD = 16
) (
    input  logic              clk,
    input  logic              clr,
    bus_arbiter_rr_if.master  bus
);
    localparam int IDX_W  = $clog2(N_CH);
    localparam int HOLD_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GRANT    = 2'd1,
        HANDOVER = 2'd2
    } state_t;

    state_t              state;
    logic [N_CH-1:0]     grant_q;
    logic [IDX_W-1:0]    owner_q;
    logic [IDX_W-1:0]    last_owner;
    logic [HOLD_W-1:0]   hold;
    logic                busy_q;
    logic                preempt_q;

    logic [IDX_W-1:0]    winner;
    logic [IDX_W-1:0]    idx;
    logic                any_req;
    logic                owner_req;
    logic                others_req;
    logic                inflight;
    logic [HOLD_W-1:0]   hold_nxt;
    logic                hold_done;

    // Winner search. Loops run from the lowest priority candidate to the
    // highest so the last hit is the winner.
    always_comb begin
        winner = '0;
        idx    = '0;
        if (RR_MODE != 0) begin
            for (int i = N_CH; i >= 1; i--) begin
                idx = IDX_W'((int'(last_owner) + i) % N_CH);
                if (bus.DMA[idx]) begin
                    winner = idx;
                end
            end
        end else begin
            for (int i = N_CH - 1; i >= 0; i--) begin
                if (bus.DMA[i]) begin
                    winner = IDX_W'(i);
                end
            end
        end
    end

    assign any_req    = |bus.DMA;
    // In GRANT, grant_q is the one-hot of the owner, so it doubles as a mask.
    assign owner_req  = |(bus.DMA & grant_q);
    assign others_req = |(bus.DMA & ~grant_q);
    assign inflight   = bus.BUS_req & ~bus.BUS_ready;

    // A grant cycle is counted as it completes, so an owner sees exactly
    // MAX_HOLD cycles of grant before the preempting edge.
    assign hold_nxt  = (hold == HOLD_W'(MAX_HOLD)) ? hold : hold + 1'b1;
    assign hold_done = (MAX_HOLD != 0) && (hold_nxt >= HOLD_W'(MAX_HOLD));

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state      <= IDLE;
            grant_q    <= '0;
            owner_q    <= '0;
            last_owner <= IDX_W'(N_CH - 1);
            hold       <= '0;
            busy_q     <= 1'b0;
            preempt_q  <= 1'b0;
        end else begin
            preempt_q <= 1'b0;
            case (state)
                GRANT: begin
                    if (!inflight && !owner_req) begin
                        state   <= HANDOVER;
                        grant_q <= '0;
                        busy_q  <= 1'b0;
                    end else if (!inflight && hold_done && others_req) begin
                        state     <= HANDOVER;
                        grant_q   <= '0;
                        busy_q    <= 1'b0;
                        preempt_q <= 1'b1;
                    end else begin
                        hold <= hold_nxt;
                    end
                end
                default: begin
                    // IDLE and HANDOVER both start a new grant when anyone asks;
                    // HANDOVER otherwise falls back to IDLE.
                    if (any_req) begin
                        state      <= GRANT;
                        grant_q    <= {{(N_CH-1){1'b0}}, 1'b1} << winner;
                        owner_q    <= winner;
                        last_owner <= winner;
                        hold       <= '0;
                        busy_q     <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.grant    = grant_q;
    assign bus.owner    = owner_q;
    assign bus.bus_busy = busy_q;
    assign bus.preempt  = preempt_q;
endmodule
